// File: rtl/hiscore_port_ctrl.sv
// rtl/hiscore_port_ctrl.sv - hiscore RAM port initiator: region-table save/restore over byte streams
module hiscore_port_ctrl #(
   parameter int ADDR_W      = 12,
   parameter int MAX_REGIONS = 4,
   parameter int RD_LAT      = 2
) (
   input  logic                           clk_49m,
   input  logic                           reset,
   input  logic                           cfg_wr,
   input  logic [$clog2(MAX_REGIONS)-1:0] cfg_idx,
   input  logic [ADDR_W-1:0]              cfg_start,
   input  logic [ADDR_W:0]                cfg_len,
   input  logic                           cmd_save,
   input  logic                           cmd_restore,
   output logic                           busy,
   output logic                           done,
   output logic                           pause_req,
   output logic [7:0]                     so_data,
   output logic                           so_valid,
   input  logic                           so_ready,
   input  logic [7:0]                     si_data,
   input  logic                           si_valid,
   output logic                           si_ready,
   output logic [ADDR_W-1:0]              hs_address,
   output logic [7:0]                     hs_data_in,
   input  logic [7:0]                     hs_data_out,
   output logic                           hs_write_enable,
   output logic                           hs_access_write
);
   localparam int IDX_W  = $clog2(MAX_REGIONS);
   localparam int WAIT_W = $clog2(RD_LAT + 1);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] NEXT   = 3'd1;
   localparam logic [2:0] S_ADDR = 3'd2;
   localparam logic [2:0] S_WAIT = 3'd3;
   localparam logic [2:0] S_OUT  = 3'd4;
   localparam logic [2:0] R_IN   = 3'd5;
   localparam logic [2:0] R_WR   = 3'd6;
   localparam logic [2:0] FINISH = 3'd7;

   logic [2:0]        state_q, state_d;
   logic [IDX_W:0]    idx_q, idx_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [7:0]        so_data_q, so_data_d;
   logic [7:0]        wdata_q, wdata_d;
   logic              restore_q, restore_d;
   logic              acc_wr_q, acc_wr_d;
   logic              done_q, done_d;

   logic [ADDR_W-1:0] start_q [MAX_REGIONS];
   logic [ADDR_W:0]   len_q   [MAX_REGIONS];
   logic [IDX_W-1:0]  cur;
   logic              last_byte;

   assign cur       = idx_q[IDX_W-1:0];
   assign last_byte = (cnt_q == (ADDR_W+1)'(1));

   always_ff @(posedge clk_49m) begin
      if (reset) begin
         for (int i = 0; i < MAX_REGIONS; i++) begin
            start_q[i] <= '0;
            len_q[i]   <= '0;
         end
      end else if (cfg_wr && state_q == IDLE) begin
         start_q[cfg_idx] <= cfg_start;
         len_q[cfg_idx]   <= cfg_len;
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      addr_d    = addr_q;
      cnt_d     = cnt_q;
      wait_d    = wait_q;
      so_data_d = so_data_q;
      wdata_d   = wdata_q;
      restore_d = restore_q;
      acc_wr_d  = acc_wr_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (cmd_save || cmd_restore) begin
               state_d   = NEXT;
               idx_d     = '0;
               restore_d = !cmd_save;
               acc_wr_d  = !cmd_save;
            end
         end
         NEXT: begin
            // The last entry finishes directly when empty, so an empty table costs MAX_REGIONS+1 busy cycles.
            if (idx_q == (IDX_W+1)'(MAX_REGIONS)) begin
               state_d = FINISH;
            end else if (len_q[cur] != '0) begin
               addr_d  = start_q[cur];
               cnt_d   = len_q[cur];
               idx_d   = idx_q + (IDX_W+1)'(1);
               state_d = restore_q ? R_IN : S_ADDR;
            end else begin
               idx_d = idx_q + (IDX_W+1)'(1);
               if (idx_q == (IDX_W+1)'(MAX_REGIONS - 1))
                  state_d = FINISH;
            end
         end
         S_ADDR: begin
            wait_d  = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (wait_q == WAIT_W'(RD_LAT - 1)) begin
               so_data_d = hs_data_out;
               state_d   = S_OUT;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         S_OUT: begin
            if (so_ready) begin
               addr_d  = addr_q + ADDR_W'(1);
               cnt_d   = cnt_q - (ADDR_W+1)'(1);
               state_d = last_byte ? NEXT : S_ADDR;
            end
         end
         R_IN: begin
            if (si_valid) begin
               wdata_d = si_data;
               state_d = R_WR;
            end
         end
         R_WR: begin
            addr_d  = addr_q + ADDR_W'(1);
            cnt_d   = cnt_q - (ADDR_W+1)'(1);
            state_d = last_byte ? NEXT : R_IN;
         end
         FINISH: begin
            done_d   = 1'b1;
            acc_wr_d = 1'b0;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_49m) begin
      if (reset) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         addr_q    <= '0;
         cnt_q     <= '0;
         wait_q    <= '0;
         so_data_q <= '0;
         wdata_q   <= '0;
         restore_q <= 1'b0;
         acc_wr_q  <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         addr_q    <= addr_d;
         cnt_q     <= cnt_d;
         wait_q    <= wait_d;
         so_data_q <= so_data_d;
         wdata_q   <= wdata_d;
         restore_q <= restore_d;
         acc_wr_q  <= acc_wr_d;
         done_q    <= done_d;
      end
   end

   assign busy            = (state_q != IDLE);
   assign pause_req       = busy;
   assign done            = done_q;
   assign so_data         = so_data_q;
   assign so_valid        = (state_q == S_OUT);
   assign si_ready        = (state_q == R_IN);
   assign hs_address      = addr_q;
   assign hs_data_in      = wdata_q;
   assign hs_write_enable = (state_q == R_WR);
   assign hs_access_write = acc_wr_q;
endmodule

// File: tb/tb_hiscore_port_ctrl.sv
// tb/tb_hiscore_port_ctrl.sv - scoreboard bench for hiscore_port_ctrl with a 2-cycle-latency RAM model
module tb_hiscore_port_ctrl;
   localparam int ADDR_W = 12;
   localparam int MAXR   = 4;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              cfg_wr = 1'b0;
   logic [1:0]        cfg_idx = '0;
   logic [ADDR_W-1:0] cfg_start = '0;
   logic [ADDR_W:0]   cfg_len = '0;
   logic              cmd_save = 1'b0, cmd_restore = 1'b0;
   logic              busy, done, pause_req;
   logic [7:0]        so_data;
   logic              so_valid;
   logic              so_ready = 1'b1;
   logic [7:0]        si_data = '0;
   logic              si_valid = 1'b0;
   logic              si_ready;
   logic [ADDR_W-1:0] hs_address;
   logic [7:0]        hs_data_in, hs_data_out;
   logic              hs_write_enable, hs_access_write;

   hiscore_port_ctrl #(.ADDR_W(ADDR_W), .MAX_REGIONS(MAXR), .RD_LAT(2)) dut (
      .clk_49m(clk), .reset(reset), .cfg_wr(cfg_wr), .cfg_idx(cfg_idx),
      .cfg_start(cfg_start), .cfg_len(cfg_len), .cmd_save(cmd_save),
      .cmd_restore(cmd_restore), .busy(busy), .done(done), .pause_req(pause_req),
      .so_data(so_data), .so_valid(so_valid), .so_ready(so_ready),
      .si_data(si_data), .si_valid(si_valid), .si_ready(si_ready),
      .hs_address(hs_address), .hs_data_in(hs_data_in), .hs_data_out(hs_data_out),
      .hs_write_enable(hs_write_enable), .hs_access_write(hs_access_write)
   );

   always #5 clk = ~clk;

   // RAM model: two register stages from address to read data
   logic [7:0]        mem [4096];
   logic [7:0]        rd1, rd2;
   logic              pl_we = 1'b0;
   logic [ADDR_W-1:0] pl_addr = '0;
   logic [7:0]        pl_data = '0;
   always @(posedge clk) begin
      if (pl_we) mem[pl_addr] <= pl_data;
      else if (hs_write_enable) mem[hs_address] <= hs_data_in;
      rd1 <= mem[hs_address];
      rd2 <= rd1;
   end
   assign hs_data_out = rd2;

   int n_checks = 0;
   int n_errors = 0;
   int so_hs = 0;
   int we_total = 0;
   int done_total = 0;
   logic in_restore = 1'b0;
   logic [19:0] so_exp [$];
   logic [19:0] wr_exp [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   initial begin : monitor
      logic        prev_stall;
      logic [7:0]  prev_data;
      logic        prev_we;
      logic        prev_done;
      logic [19:0] e;
      prev_stall = 1'b0;
      prev_data  = '0;
      prev_we    = 1'b0;
      prev_done  = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (prev_stall) begin
               check("so_valid_hold", so_valid, 1);
               check("so_data_hold", so_data, prev_data);
            end
            if (so_valid && so_ready) begin
               so_hs++;
               if (so_exp.size() == 0) check("so_extra", 1, 0);
               else begin
                  e = so_exp.pop_front();
                  check("so_addr", hs_address, e[19:8]);
                  check("so_data", so_data, e[7:0]);
               end
            end
            if (hs_write_enable) begin
               we_total++;
               check("we_pulse", prev_we, 0);
               check("we_acc", hs_access_write, 1);
               if (wr_exp.size() == 0) check("wr_extra", 1, 0);
               else begin
                  e = wr_exp.pop_front();
                  check("wr_addr", hs_address, e[19:8]);
                  check("wr_data", hs_data_in, e[7:0]);
               end
            end
            if (in_restore && busy) check("acc_hold", hs_access_write, 1);
            if (done) begin
               done_total++;
               check("done_pulse", prev_done, 0);
            end
         end
         prev_stall = so_valid && !so_ready;
         prev_data  = so_data;
         prev_we    = hs_write_enable;
         prev_done  = done;
      end
   end

   task automatic cfg_write(input int idx, input int start, input int len);
      @(posedge clk); #1;
      cfg_wr = 1'b1; cfg_idx = 2'(idx); cfg_start = 12'(start); cfg_len = 13'(len);
      @(posedge clk); #1;
      cfg_wr = 1'b0;
   endtask

   task automatic poke(input int addr, input logic [7:0] d);
      @(posedge clk); #1;
      pl_we = 1'b1; pl_addr = 12'(addr); pl_data = d;
      @(posedge clk); #1;
      pl_we = 1'b0;
   endtask

   task automatic pulse_cmd(input logic s, input logic r);
      @(posedge clk); #1;
      cmd_save = s; cmd_restore = r;
      @(posedge clk); #1;
      cmd_save = 1'b0; cmd_restore = 1'b0;
   endtask

   task automatic wait_done(input int limit, output int busy_cycles);
      int n;
      busy_cycles = 0;
      n = 0;
      forever begin
         @(negedge clk);
         if (busy) busy_cycles++;
         if (done) break;
         n++;
         if (n > limit) begin
            check("done_timeout", 1, 0);
            break;
         end
      end
   endtask

   task automatic send_si(input logic [7:0] b, input int gap);
      int n;
      repeat (gap) @(posedge clk);
      #1;
      si_data = b; si_valid = 1'b1;
      n = 0;
      forever begin
         @(negedge clk);
         if (si_ready) break;
         n++;
         if (n > 200) begin
            check("si_timeout", 1, 0);
            break;
         end
      end
      @(posedge clk); #1;
      si_valid = 1'b0;
   endtask

   initial begin
      int bc, hs0, we0, d0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_pause", pause_req, 0);
      check("rst_so_valid", so_valid, 0);
      check("rst_si_ready", si_ready, 0);
      check("rst_we", hs_write_enable, 0);
      check("rst_acc", hs_access_write, 0);
      check("rst_addr", hs_address, 0);

      // save, single region
      cfg_write(0, 'h100, 3);
      poke('h100, 8'hAA); poke('h101, 8'hBB); poke('h102, 8'hCC);
      so_exp.push_back({12'h100, 8'hAA});
      so_exp.push_back({12'h101, 8'hBB});
      so_exp.push_back({12'h102, 8'hCC});
      hs0 = so_hs; we0 = we_total;
      pulse_cmd(1, 0);
      check("save_busy_rise", busy, 1);
      check("save_pause", pause_req, 1);
      check("save_acc", hs_access_write, 0);
      wait_done(200, bc);
      check("save_busy_fall", busy, 0);
      check("save_bytes", so_hs - hs0, 3);
      check("save_no_we", we_total - we0, 0);
      check("save_q_empty", so_exp.size(), 0);

      // restore with si_valid gaps, two regions
      cfg_write(0, 'h010, 2);
      cfg_write(1, 'h200, 1);
      wr_exp.push_back({12'h010, 8'h11});
      wr_exp.push_back({12'h011, 8'h22});
      wr_exp.push_back({12'h200, 8'h33});
      we0 = we_total;
      in_restore = 1'b1;
      pulse_cmd(0, 1);
      check("rest_acc_rise", hs_access_write, 1);
      fork
         wait_done(400, bc);
         begin
            send_si(8'h11, 3);
            send_si(8'h22, 0);
            send_si(8'h33, 5);
         end
      join
      in_restore = 1'b0;
      check("rest_acc_fall", hs_access_write, 0);
      check("rest_we_count", we_total - we0, 3);
      check("rest_q_empty", wr_exp.size(), 0);
      check("ram_010", mem['h010], 8'h11);
      check("ram_011", mem['h011], 8'h22);
      check("ram_200", mem['h200], 8'h33);

      // backpressure mid-stream
      cfg_write(0, 'h100, 3);
      cfg_write(1, 'h200, 0);
      so_exp.push_back({12'h100, 8'hAA});
      so_exp.push_back({12'h101, 8'hBB});
      so_exp.push_back({12'h102, 8'hCC});
      hs0 = so_hs;
      pulse_cmd(1, 0);
      fork
         wait_done(400, bc);
         begin
            for (int n = 0; n < 100 && so_hs < hs0 + 1; n++) @(negedge clk);
            @(posedge clk); #1 so_ready = 1'b0;
            repeat (10) @(posedge clk);
            #1 so_ready = 1'b1;
         end
      join
      check("bp_bytes", so_hs - hs0, 3);
      check("bp_q_empty", so_exp.size(), 0);

      // wrap and skip
      cfg_write(0, 'h100, 0);
      cfg_write(1, 'h300, 0);
      cfg_write(2, 'hFFF, 2);
      poke('hFFF, 8'h5A); poke('h000, 8'hA5);
      so_exp.push_back({12'hFFF, 8'h5A});
      so_exp.push_back({12'h000, 8'hA5});
      hs0 = so_hs; we0 = we_total;
      pulse_cmd(1, 0);
      wait_done(200, bc);
      check("wrap_bytes", so_hs - hs0, 2);
      check("wrap_q_empty", so_exp.size(), 0);

      // save+restore together, then commands/config while busy
      so_exp.push_back({12'hFFF, 8'h5A});
      so_exp.push_back({12'h000, 8'hA5});
      pulse_cmd(1, 1);
      check("conf_acc", hs_access_write, 0);
      check("conf_busy", busy, 1);
      @(posedge clk); #1;
      cmd_restore = 1'b1; cfg_wr = 1'b1; cfg_idx = 2'd2; cfg_start = 12'h000; cfg_len = 13'd5;
      @(posedge clk); #1;
      cmd_restore = 1'b0; cfg_wr = 1'b0;
      wait_done(200, bc);
      so_exp.push_back({12'hFFF, 8'h5A});
      so_exp.push_back({12'h000, 8'hA5});
      pulse_cmd(1, 0);
      wait_done(200, bc);
      check("conf_bytes", so_hs - hs0, 6);
      check("conf_no_we", we_total - we0, 0);
      check("conf_q_empty", so_exp.size(), 0);

      // reset mid-restore after one byte
      cfg_write(0, 'h020, 3);
      wr_exp.push_back({12'h020, 8'h77});
      we0 = we_total;
      in_restore = 1'b1;
      pulse_cmd(0, 1);
      send_si(8'h77, 1);
      d0 = done_total;
      @(posedge clk); #1 reset = 1'b1;
      in_restore = 1'b0;
      @(posedge clk); #1;
      check("mid_rst_acc", hs_access_write, 0);
      check("mid_rst_we", hs_write_enable, 0);
      check("mid_rst_busy", busy, 0);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      check("mid_rst_no_done", done_total, d0);
      check("mid_rst_we_count", we_total - we0, 1);
      check("mid_rst_q_empty", wr_exp.size(), 0);
      check("mid_rst_ram", mem['h020], 8'h77);
      hs0 = so_hs;
      pulse_cmd(1, 0);
      wait_done(100, bc);
      check("empty_busy_cycles", bc, MAXR + 1);
      check("empty_no_stream", so_hs - hs0, 0);
      check("empty_done", done_total, d0 + 1);

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
